regfile_hilo: RTL and testbench

Architectural register file: 32×32 GPRs plus HI/LO, with write-first read bypass and a registered commit-trace port. It is the sink of the writeback stage and consumes the WB stage's final result, destination and write-type outputs. It is also the source for the decode stage's two operand read ports. Writes are suppressed whenever the writeback stage has already masked its write type (D-cache stall, flush).

---
 rtl/regfile_hilo_pkg.sv | 17 +
 rtl/regfile_hilo_hilo_reg.sv | 45 ++++
 rtl/regfile_hilo.sv | 122 ++++++++++++
 tb/tb_regfile_hilo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_hilo_pkg.sv
// rtl/regfile_hilo_pkg.sv - shared CPU defines for the register file slice
//
// Purpose: write-type struct produced by the writeback stage, the hardwired
// zero-register index and the commit-trace byte-enable constant.
package regfile_hilo_pkg;

  // Write enables leaving the WB stage, already masked for stalls/flushes.
  typedef struct packed {
    logic RFWr;
    logic LOWr;
    logic HIWr;
  } RegsWrType;

  localparam int unsigned REG_ZERO  = 0;
  localparam logic [3:0]  TRACE_WEN = 4'hF;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// rtl/regfile_hilo_hilo_reg.sv - HI/LO register pair with data select and bypass
//
// Purpose: holds HI and LO; each loads either the GPR result (MTHI/MTLO) or
// the multiply/divide result, and the outputs forward the value being
// written in the current cycle.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   hi_wr_i, lo_wr_i       independent write enables
//   hilo_sel_i             0 = take result_i, 1 = take hi_data_i/lo_data_i
//   result_i               GPR result data
//   hi_data_i, lo_data_i   multiply/divide result halves
//   hi_o, lo_o             current HI/LO, write-first bypassed
module hilo_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hi_wr_i,
  input  logic        lo_wr_i,
  input  logic        hilo_sel_i,
  input  logic [31:0] result_i,
  input  logic [31:0] hi_data_i,
  input  logic [31:0] lo_data_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_d, lo_d;

  assign hi_d = hilo_sel_i ? hi_data_i : result_i;
  assign lo_d = hilo_sel_i ? lo_data_i : result_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_wr_i) hi_q <= hi_d;
      if (lo_wr_i) lo_q <= lo_d;
    end
  end

  assign hi_o = hi_wr_i ? hi_d : hi_q;
  assign lo_o = lo_wr_i ? lo_d : lo_q;

endmodule

// File: rtl/regfile_hilo.sv
// rtl/regfile_hilo.sv - architectural GPR file with HI/LO and commit trace
//
// Purpose: 32x32 GPRs (r0 hardwired to zero) written from WB, two
// write-first bypassed read ports for decode, HI/LO via hilo_reg, and a
// registered commit-trace port reporting GPR writes one cycle late.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   WB_Final_Wr                      masked {RFWr, LOWr, HIWr}
//   WB_Dst, WB_Result                GPR destination and data
//   WB_HIData, WB_LOData, WB_HiLoSel HI/LO data and source select
//   WB_PC                            PC of the committing instruction
//   ID_rs, ID_rt / ID_BusA, ID_BusB  read indices / read data
//   ID_HI, ID_LO                     current HI/LO
//   debug_wb_*                       commit trace of the last GPR write
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter bit TRACE_EN = 1'b1,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  RegsWrType        WB_Final_Wr,
  input  logic [IDX_W-1:0] WB_Dst,
  input  logic [31:0]      WB_Result,
  input  logic [31:0]      WB_HIData,
  input  logic [31:0]      WB_LOData,
  input  logic             WB_HiLoSel,
  input  logic [31:0]      WB_PC,
  input  logic [IDX_W-1:0] ID_rs,
  input  logic [IDX_W-1:0] ID_rt,
  output logic [31:0]      ID_BusA,
  output logic [31:0]      ID_BusB,
  output logic [31:0]      ID_HI,
  output logic [31:0]      ID_LO,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [IDX_W-1:0] debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(REG_ZERO);

  logic [31:0] gpr_q [NUM_REGS];
  logic        gpr_we;

  assign gpr_we = WB_Final_Wr.RFWr && (WB_Dst != ZERO_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
    end else if (gpr_we) begin
      gpr_q[WB_Dst] <= WB_Result;
    end
  end

  // Write-first: a matching write in WB overrides the stored value. gpr_we
  // already excludes r0, so r0 always falls through to the forced zero.
  always_comb begin
    ID_BusA = '0;
    if (gpr_we && (WB_Dst == ID_rs))  ID_BusA = WB_Result;
    else if (ID_rs != ZERO_IDX)       ID_BusA = gpr_q[ID_rs];
  end

  always_comb begin
    ID_BusB = '0;
    if (gpr_we && (WB_Dst == ID_rt))  ID_BusB = WB_Result;
    else if (ID_rt != ZERO_IDX)       ID_BusB = gpr_q[ID_rt];
  end

  hilo_reg u_hilo (
    .clk_i      (clk),
    .rst_i      (rst),
    .hi_wr_i    (WB_Final_Wr.HIWr),
    .lo_wr_i    (WB_Final_Wr.LOWr),
    .hilo_sel_i (WB_HiLoSel),
    .result_i   (WB_Result),
    .hi_data_i  (WB_HIData),
    .lo_data_i  (WB_LOData),
    .hi_o       (ID_HI),
    .lo_o       (ID_LO)
  );

  generate
    if (TRACE_EN) begin : g_trace
      logic [31:0]      pc_q;
      logic [3:0]       wen_q;
      logic [IDX_W-1:0] wnum_q;
      logic [31:0]      wdata_q;

      // Writes to r0 are still traced (the instruction committed) but report
      // the architecturally visible data, which is zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_q    <= '0;
          wen_q   <= '0;
          wnum_q  <= '0;
          wdata_q <= '0;
        end else if (WB_Final_Wr.RFWr) begin
          pc_q    <= WB_PC;
          wen_q   <= TRACE_WEN;
          wnum_q  <= WB_Dst;
          wdata_q <= (WB_Dst == ZERO_IDX) ? 32'h0 : WB_Result;
        end else begin
          wen_q   <= '0;
        end
      end

      assign debug_wb_pc       = pc_q;
      assign debug_wb_rf_wen   = wen_q;
      assign debug_wb_rf_wnum  = wnum_q;
      assign debug_wb_rf_wdata = wdata_q;
    end else begin : g_no_trace
      assign debug_wb_pc       = '0;
      assign debug_wb_rf_wen   = '0;
      assign debug_wb_rf_wnum  = '0;
      assign debug_wb_rf_wdata = '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_hilo.sv
// tb/tb_regfile_hilo.sv - self-checking bench for regfile_hilo
module tb_regfile_hilo;
  import regfile_hilo_pkg::*;

  logic        clk;
  logic        rst;
  RegsWrType   WB_Final_Wr;
  logic [4:0]  WB_Dst;
  logic [31:0] WB_Result, WB_HIData, WB_LOData, WB_PC;
  logic        WB_HiLoSel;
  logic [4:0]  ID_rs, ID_rt;
  logic [31:0] ID_BusA, ID_BusB, ID_HI, ID_LO;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  regfile_hilo #(.NUM_REGS(32), .TRACE_EN(1'b1)) dut (
    .clk               (clk),
    .rst               (rst),
    .WB_Final_Wr       (WB_Final_Wr),
    .WB_Dst            (WB_Dst),
    .WB_Result         (WB_Result),
    .WB_HIData         (WB_HIData),
    .WB_LOData         (WB_LOData),
    .WB_HiLoSel        (WB_HiLoSel),
    .WB_PC             (WB_PC),
    .ID_rs             (ID_rs),
    .ID_rt             (ID_rt),
    .ID_BusA           (ID_BusA),
    .ID_BusB           (ID_BusB),
    .ID_HI             (ID_HI),
    .ID_LO             (ID_LO),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic [2:0] wr, input logic [4:0] dst,
                       input logic [31:0] res, input logic [31:0] hid,
                       input logic [31:0] lod, input logic sel,
                       input logic [31:0] pc);
    WB_Final_Wr = wr;
    WB_Dst      = dst;
    WB_Result   = res;
    WB_HIData   = hid;
    WB_LOData   = lod;
    WB_HiLoSel  = sel;
    WB_PC       = pc;
  endtask

  task automatic idle();
    drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance one edge and sample away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_trace(input string tag, input logic [31:0] pc,
                            input logic [3:0] wen, input logic [4:0] wnum,
                            input logic [31:0] wdata);
    sb_push({tag, "_pc"},    pc);
    sb_push({tag, "_wen"},   {28'h0, wen});
    sb_push({tag, "_wnum"},  {27'h0, wnum});
    sb_push({tag, "_wdata"}, wdata);
  endtask

  task automatic check_trace();
    sb_check(debug_wb_pc);
    sb_check({28'h0, debug_wb_rf_wen});
    sb_check({27'h0, debug_wb_rf_wnum});
    sb_check(debug_wb_rf_wdata);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    ID_rs = 5'd5;
    ID_rt = 5'd0;
    #1 rst = 1'b1;
    #1;
    // Reset state, before any clock edge
    sb_push("rst_busa", 32'h0); sb_check(ID_BusA);
    sb_push("rst_hi",   32'h0); sb_check(ID_HI);
    sb_push("rst_lo",   32'h0); sb_check(ID_LO);
    push_trace("rst", 32'h0, 4'h0, 5'd0, 32'h0); check_trace();
    tick();
    tick();
    rst = 1'b0;

    // Write/bypass r3
    drive(3'b100, 5'd3, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'h0000_0100);
    ID_rs = 5'd3;
    #1;
    sb_push("wr3_bypass", 32'hDEADBEEF); sb_check(ID_BusA);
    tick();
    idle();
    #1;
    sb_push("wr3_stored", 32'hDEADBEEF); sb_check(ID_BusA);
    push_trace("wr3_trace", 32'h0000_0100, 4'hF, 5'd3, 32'hDEADBEEF); check_trace();
    tick();
    push_trace("idle_trace", 32'h0000_0100, 4'h0, 5'd3, 32'hDEADBEEF); check_trace();

    // Register 0
    drive(3'b100, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 32'h0000_0104);
    ID_rt = 5'd0;
    ID_rs = 5'd0;
    #1;
    sb_push("r0_busb_now", 32'h0); sb_check(ID_BusB);
    sb_push("r0_busa_now", 32'h0); sb_check(ID_BusA);
    tick();
    idle();
    #1;
    sb_push("r0_busb_later", 32'h0); sb_check(ID_BusB);
    push_trace("r0_trace", 32'h0000_0104, 4'hF, 5'd0, 32'h0); check_trace();

    // Masked write: preload r7, then present a write with enables cleared
    drive(3'b100, 5'd7, 32'h77, 32'h0, 32'h0, 1'b0, 32'h0000_0108);
    tick();
    drive(3'b000, 5'd7, 32'h55, 32'h0, 32'h0, 1'b0, 32'h0000_010C);
    ID_rs = 5'd7;
    ID_rt = 5'd7;
    #1;
    sb_push("mask_no_bypass", 32'h77); sb_check(ID_BusA);
    tick();
    idle();
    #1;
    sb_push("mask_r7_kept", 32'h77); sb_check(ID_BusB);
    push_trace("mask_trace", 32'h0000_0108, 4'h0, 5'd7, 32'h77); check_trace();

    // Multiply result together with a GPR write
    drive(3'b111, 5'd4, 32'h9, 32'h1, 32'h2, 1'b1, 32'h0000_0110);
    ID_rs = 5'd4;
    #1;
    sb_push("mult_hi_byp", 32'h1); sb_check(ID_HI);
    sb_push("mult_lo_byp", 32'h2); sb_check(ID_LO);
    sb_push("mult_r4_byp", 32'h9); sb_check(ID_BusA);
    tick();
    idle();
    #1;
    sb_push("mult_hi_st", 32'h1); sb_check(ID_HI);
    sb_push("mult_lo_st", 32'h2); sb_check(ID_LO);
    sb_push("mult_r4_st", 32'h9); sb_check(ID_BusA);
    push_trace("mult_trace", 32'h0000_0110, 4'hF, 5'd4, 32'h9); check_trace();

    // MTHI/MTLO from WB_Result, no trace entry
    drive(3'b011, 5'd4, 32'h33, 32'hAA, 32'hBB, 1'b0, 32'h0000_0114);
    #1;
    sb_push("mt_hi_byp", 32'h33); sb_check(ID_HI);
    sb_push("mt_lo_byp", 32'h33); sb_check(ID_LO);
    sb_push("mt_r4_nobyp", 32'h9); sb_check(ID_BusA);
    tick();
    // HI-only write: LO must hold
    drive(3'b001, 5'd0, 32'h44, 32'h0, 32'h0, 1'b0, 32'h0000_0118);
    #1;
    push_trace("mt_trace", 32'h0000_0110, 4'h0, 5'd4, 32'h9); check_trace();
    sb_push("hionly_hi_byp", 32'h44); sb_check(ID_HI);
    sb_push("hionly_lo_held", 32'h33); sb_check(ID_LO);
    tick();
    idle();
    #1;
    sb_push("hionly_hi_st", 32'h44); sb_check(ID_HI);
    sb_push("hionly_lo_st", 32'h33); sb_check(ID_LO);

    // Back-to-back writes to r8
    ID_rs = 5'd8;
    drive(3'b100, 5'd8, 32'hA, 32'h0, 32'h0, 1'b0, 32'h0000_0120);
    #1;
    sb_push("ord_first", 32'hA); sb_check(ID_BusA);
    tick();
    drive(3'b100, 5'd8, 32'hB, 32'h0, 32'h0, 1'b0, 32'h0000_0124);
    #1;
    sb_push("ord_second", 32'hB); sb_check(ID_BusA);
    tick();
    idle();
    #1;
    sb_push("ord_final", 32'hB); sb_check(ID_BusA);
    push_trace("ord_trace", 32'h0000_0124, 4'hF, 5'd8, 32'hB); check_trace();

    // Asynchronous reset mid-cycle after writing r5
    drive(3'b100, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0000_0130);
    tick();
    idle();
    ID_rs = 5'd5;
    #1;
    sb_push("pre_rst_r5", 32'h1234); sb_check(ID_BusA);
    #1 rst = 1'b1;
    #1;
    sb_push("arst_r5", 32'h0); sb_check(ID_BusA);
    sb_push("arst_r8_via_b", 32'h0);
    ID_rt = 5'd8;
    #1 sb_check(ID_BusB);
    sb_push("arst_hi", 32'h0); sb_check(ID_HI);
    sb_push("arst_lo", 32'h0); sb_check(ID_LO);
    push_trace("arst", 32'h0, 4'h0, 5'd0, 32'h0); check_trace();

    // A write presented under reset is discarded
    tick();
    drive(3'b100, 5'd9, 32'h999, 32'h0, 32'h0, 1'b0, 32'h0000_0140);
    tick();
    rst = 1'b0;
    idle();
    ID_rs = 5'd9;
    #1;
    sb_push("rst_wr_dropped", 32'h0); sb_check(ID_BusA);
    push_trace("rst_wr_trace", 32'h0, 4'h0, 5'd0, 32'h0); check_trace();

    // First write after release lands at the next edge
    drive(3'b100, 5'd9, 32'hABC, 32'h0, 32'h0, 1'b0, 32'h0000_0150);
    tick();
    idle();
    #1;
    sb_push("post_rst_r9", 32'hABC); sb_check(ID_BusA);
    push_trace("post_rst_trace", 32'h0000_0150, 4'hF, 5'd9, 32'hABC); check_trace();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
